// File: rtl/link_master_if.sv
// Producer-side and link-side signals of the req/ack byte link master.
// Latency: none, wires only; all timing lives in the master and slave.
// Backpressure: full/overflow toward the producer, req/ack toward the slave.
interface link_master_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       overflow;
    logic       ack;
    logic       req;
    logic [7:0] data_out;
    logic       busy;
    logic [7:0] tx_count;
    logic       done;

    modport master (
        input  wr_en, wr_data, ack,
        output full, overflow, req, data_out, busy, tx_count, done
    );

    modport slave (
        output wr_en, wr_data, ack,
        input  full, overflow, req, data_out, busy, tx_count, done
    );
endinterface

// File: rtl/link_master_fsm.sv
// Buffers producer bytes in a small FIFO and sends them one at a time over a 4-phase req/ack link.
// Latency: a byte written into an empty FIFO while idle shows up on req/data_out one edge later.
// Backpressure: full blocks writes (dropped bytes set sticky overflow); req is held until ack.
module link_master_fsm #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    link_master_if.master lm
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        M_IDLE     = 2'd0,
        M_REQ      = 2'd1,
        M_WAIT_LOW = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          overflow_q;

    // FSM and registered link outputs
    state_t     state;
    state_t     state_nxt;
    logic       req_q;
    logic       req_nxt;
    logic [7:0] dout_q;
    logic [7:0] dout_nxt;
    logic [7:0] cnt_q;
    logic [7:0] cnt_nxt;
    logic       done_q;
    logic       done_nxt;

    // Full is taken from the occupancy at the start of the cycle, so a pop never
    // makes room for a write in the same cycle.
    assign full  = (occ == (AW+1)'(DEPTH));
    assign empty = (occ == '0);
    assign push  = lm.wr_en && !full;

    // Data array: no reset needed, occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= lm.wr_data;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (lm.wr_en && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // State register together with the registered link outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= M_IDLE;
            req_q  <= 1'b0;
            dout_q <= 8'h00;
            cnt_q  <= 8'h00;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            req_q  <= req_nxt;
            dout_q <= dout_nxt;
            cnt_q  <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state logic: pop only from idle with ack low, complete on ack falling.
    always_comb begin
        state_nxt = state;
        req_nxt   = req_q;
        dout_nxt  = dout_q;
        cnt_nxt   = cnt_q;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        case (state)
            M_IDLE: begin
                req_nxt = 1'b0;
                // A stale ack left over from the previous byte holds off the next request.
                if (!empty && !lm.ack) begin
                    pop       = 1'b1;
                    dout_nxt  = mem[rd_ptr];
                    req_nxt   = 1'b1;
                    state_nxt = M_REQ;
                end
            end
            M_REQ: begin
                req_nxt = 1'b1;
                if (lm.ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = M_WAIT_LOW;
                end
            end
            M_WAIT_LOW: begin
                req_nxt = 1'b0;
                if (!lm.ack) begin
                    cnt_nxt   = cnt_q + 8'd1;
                    // Emptiness before any same-cycle write decides the drain pulse.
                    done_nxt  = empty;
                    state_nxt = M_IDLE;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = M_IDLE;
            end
        endcase
    end

    assign lm.full     = full;
    assign lm.overflow = overflow_q;
    assign lm.req      = req_q;
    assign lm.data_out = dout_q;
    assign lm.busy     = (state != M_IDLE) || !empty;
    assign lm.tx_count = cnt_q;
    assign lm.done     = done_q;
endmodule

// File: tb/tb_link_master_fsm.sv
// Self-checking bench for link_master_fsm: vector table, directed link sequences, random scoreboard.
// Latency: outputs are sampled on the falling edge after each rising edge.
// Backpressure: a bench-side link slave answers req with ack; it can be switched off to stall the master.
module tb_link_master_fsm;
    localparam int DEPTH = 4;
    localparam int NV    = 28;

    logic clk = 1'b0;
    logic rst = 1'b1;

    link_master_if lmi ();

    link_master_fsm #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .lm  (lmi)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic slave_en  = 1'b0;
    logic slave_ack = 1'b0;
    logic man_ack   = 1'b0;
    assign lmi.ack = slave_en ? slave_ack : man_ack;

    logic [7:0] rx_q[$];
    int         done_total = 0;

    // {rst, wr_en, wr_data, ack} applied before an edge; exp = {req, data_out, full, busy, tx_count, done, overflow} after it.
    typedef struct packed {
        logic        rst;
        logic        wr;
        logic [7:0]  wd;
        logic        ack;
        logic [20:0] exp;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t mk(input logic [2:0] rwa, input logic [7:0] wd, input logic [3:0] flg,
                                input logic [7:0] dout, input logic [7:0] cnt, input logic ovf);
        vec_t v;
        v.rst = rwa[2];
        v.wr  = rwa[1];
        v.ack = rwa[0];
        v.wd  = wd;
        // flg = {req, full, busy, done}
        v.exp = {flg[3], dout, flg[2], flg[1], cnt, flg[0], ovf};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Link slave: raises ack the edge after it sees req, drops it the edge after req falls.
    initial begin
        logic       r;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            r = lmi.req;
            d = lmi.data_out;
            @(posedge clk);
            #1;
            if (rst || !slave_en) begin
                slave_ack = 1'b0;
            end else if (r && !slave_ack) begin
                slave_ack = 1'b1;
                rx_q.push_back(d);
            end else if (!r && slave_ack) begin
                slave_ack = 1'b0;
            end
        end
    end

    // Count done pulses, sampled just after the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (lmi.done === 1'b1) done_total++;
        end
    end

    // Hard stop in case the whole run wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        lmi.wr_en   = 1'b0;
        lmi.wr_data = 8'h00;
        man_ack     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        lmi.wr_en   = 1'b1;
        lmi.wr_data = b;
        @(negedge clk);
        lmi.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((lmi.busy !== 1'b0 || lmi.ack !== 1'b0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain_in_budget"}, 32'(k < 400), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int         base;
        int         d0;
        int         occ;
        bit         ovf_m;
        bit         w;
        int         rate;
        logic [7:0] d;
        logic       req_prev;
        logic [7:0] exp_q[$];

        lmi.wr_en   = 1'b0;
        lmi.wr_data = 8'h00;

        // ---------------- vector table (slave off, ack driven directly) ----------------
        vt[0]  = mk(3'b000, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0);
        vt[1]  = mk(3'b010, 8'hA5, 4'b0010, 8'h00, 8'h00, 1'b0);
        vt[2]  = mk(3'b000, 8'h00, 4'b1010, 8'hA5, 8'h00, 1'b0);
        vt[3]  = mk(3'b000, 8'h00, 4'b1010, 8'hA5, 8'h00, 1'b0);
        vt[4]  = mk(3'b001, 8'h00, 4'b0010, 8'hA5, 8'h00, 1'b0);
        vt[5]  = mk(3'b001, 8'h00, 4'b0010, 8'hA5, 8'h00, 1'b0);
        vt[6]  = mk(3'b000, 8'h00, 4'b0001, 8'hA5, 8'h01, 1'b0);
        vt[7]  = mk(3'b000, 8'h00, 4'b0000, 8'hA5, 8'h01, 1'b0);
        vt[8]  = mk(3'b011, 8'h5A, 4'b0010, 8'hA5, 8'h01, 1'b0);
        vt[9]  = mk(3'b001, 8'h00, 4'b0010, 8'hA5, 8'h01, 1'b0);
        vt[10] = mk(3'b001, 8'h00, 4'b0010, 8'hA5, 8'h01, 1'b0);
        vt[11] = mk(3'b000, 8'h00, 4'b1010, 8'h5A, 8'h01, 1'b0);
        vt[12] = mk(3'b001, 8'h00, 4'b0010, 8'h5A, 8'h01, 1'b0);
        vt[13] = mk(3'b010, 8'h77, 4'b0011, 8'h5A, 8'h02, 1'b0);
        vt[14] = mk(3'b000, 8'h00, 4'b1010, 8'h77, 8'h02, 1'b0);
        vt[15] = mk(3'b010, 8'h01, 4'b1010, 8'h77, 8'h02, 1'b0);
        vt[16] = mk(3'b010, 8'h02, 4'b1010, 8'h77, 8'h02, 1'b0);
        vt[17] = mk(3'b010, 8'h03, 4'b1010, 8'h77, 8'h02, 1'b0);
        vt[18] = mk(3'b010, 8'h04, 4'b1110, 8'h77, 8'h02, 1'b0);
        vt[19] = mk(3'b010, 8'h05, 4'b1110, 8'h77, 8'h02, 1'b1);
        vt[20] = mk(3'b001, 8'h00, 4'b0110, 8'h77, 8'h02, 1'b1);
        vt[21] = mk(3'b000, 8'h00, 4'b0110, 8'h77, 8'h03, 1'b1);
        vt[22] = mk(3'b010, 8'h06, 4'b1010, 8'h01, 8'h03, 1'b1);
        vt[23] = mk(3'b100, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0);
        vt[24] = mk(3'b010, 8'hC3, 4'b0010, 8'h00, 8'h00, 1'b0);
        vt[25] = mk(3'b000, 8'h00, 4'b1010, 8'hC3, 8'h00, 1'b0);
        vt[26] = mk(3'b001, 8'h00, 4'b0010, 8'hC3, 8'h00, 1'b0);
        vt[27] = mk(3'b000, 8'h00, 4'b0001, 8'hC3, 8'h01, 1'b0);

        slave_en = 1'b0;
        do_reset();
        for (int i = 0; i < NV; i++) begin
            rst         = vt[i].rst;
            lmi.wr_en   = vt[i].wr;
            lmi.wr_data = vt[i].wd;
            man_ack     = vt[i].ack;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  32'({lmi.req, lmi.data_out, lmi.full, lmi.busy, lmi.tx_count, lmi.done, lmi.overflow}),
                  32'(vt[i].exp));
        end
        rst       = 1'b0;
        lmi.wr_en = 1'b0;
        man_ack   = 1'b0;

        // ---------------- burst of four with slave attached ----------------
        slave_en = 1'b1;
        do_reset();
        base = rx_q.size();
        d0   = done_total;
        wr_byte(8'h11);
        wr_byte(8'h22);
        wr_byte(8'h33);
        wr_byte(8'h44);
        check("burst_full_after_writes", 32'(lmi.full), 32'd0);
        wait_idle("burst");
        check("burst_rx_count", 32'(rx_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < rx_q.size())
                check($sformatf("burst_byte%0d", i), 32'(rx_q[base+i]), 32'(8'h11 * (i + 1)));
        end
        check("burst_tx_count", 32'(lmi.tx_count), 32'd4);
        check("burst_done_pulses", 32'(done_total - d0), 32'd1);
        check("burst_busy", 32'(lmi.busy), 32'd0);

        // ---------------- overflow with master stalled in M_REQ ----------------
        slave_en = 1'b0;
        do_reset();
        base = rx_q.size();
        for (int i = 0; i < 6; i++) begin
            d = 8'hB0 + 8'(i);
            wr_byte(d);
        end
        check("ovf_flag", 32'(lmi.overflow), 32'd1);
        check("ovf_full", 32'(lmi.full), 32'd1);
        check("ovf_req_held", 32'(lmi.req), 32'd1);
        slave_en = 1'b1;
        wait_idle("ovf");
        check("ovf_rx_count", 32'(rx_q.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < rx_q.size())
                check($sformatf("ovf_byte%0d", i), 32'(rx_q[base+i]), 32'(8'hB0 + i));
        end
        check("ovf_sticky", 32'(lmi.overflow), 32'd1);
        check("ovf_tx_count", 32'(lmi.tx_count), 32'd5);

        // ---------------- 257 single-byte transfers: counter and pointer wrap ----------------
        do_reset();
        base = rx_q.size();
        for (int i = 0; i < 257; i++) begin
            d = i[7:0];
            wr_byte(d);
            wait_idle("wrap");
            if (base + i < rx_q.size())
                check($sformatf("wrap_byte%0d", i), 32'(rx_q[base+i]), 32'(d));
            else
                check($sformatf("wrap_missing%0d", i), 32'(rx_q.size()), 32'(base + i + 1));
            check($sformatf("wrap_tx%0d", i), 32'(lmi.tx_count), 32'((i + 1) % 256));
        end

        // ---------------- random producer against a FIFO occupancy scoreboard ----------------
        do_reset();
        base     = rx_q.size();
        occ      = 0;
        ovf_m    = 1'b0;
        req_prev = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rate        = ((c / 500) % 2 == 0) ? 40 : 8;
            w           = ($urandom_range(0, 99) < rate);
            d           = 8'($urandom);
            lmi.wr_en   = w;
            lmi.wr_data = d;
            @(negedge clk);
            // A write lands only if the FIFO was not already full before this edge.
            if (w) begin
                if (occ < DEPTH) begin
                    exp_q.push_back(d);
                    occ++;
                end else begin
                    ovf_m = 1'b1;
                end
            end
            // Each new request means one byte left the FIFO.
            if (lmi.req && !req_prev) occ--;
            req_prev = lmi.req;
            check("rnd_full", 32'(lmi.full), 32'(occ == DEPTH));
        end
        lmi.wr_en = 1'b0;
        wait_idle("rnd");
        check("rnd_rx_count", 32'(rx_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < rx_q.size() && rx_q[base+i] !== exp_q[i])
                check($sformatf("rnd_byte%0d", i), 32'(rx_q[base+i]), 32'(exp_q[i]));
        end
        n_tests++;
        check("rnd_tx_count", 32'(lmi.tx_count), 32'(exp_q.size() % 256));
        check("rnd_overflow", 32'(lmi.overflow), 32'(ovf_m));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
